// File: rtl/pll_lock_monitor.sv
// -----------------------------------------------------------------------------
// pll_lock_monitor
//
// Checks that the PLL output clock (clk_i) runs at the expected multiple of a
// slower reference clock. clk_i cycles are counted over a window of REF_EDGES
// reference rising edges. Windows run back-to-back, and each one is judged good
// or bad against EXP_CYCLES +/- TOL. Lock is declared after LOCK_WINDOWS
// consecutive good windows. A reference that stops toggling for TIMEOUT cycles
// is reported as a stall.
//
// Ports
//   clk_i          in   1   PLL output clock; all logic on its rising edge
//   rst_i          in   1   synchronous, active-high reset
//   ref_i          in   1   reference clock, asynchronous, sampled as data
//   en_i           in   1   monitor enable; low forces IDLE
//   lock_o         out  1   frequency lock indication
//   count_o        out  CW  clk_i cycle count of the last completed window
//   count_valid_o  out  1   one-cycle pulse when count_o updates
//   timeout_o      out  1   reference stall indication (level)
// -----------------------------------------------------------------------------
module pll_lock_monitor #(
   parameter int unsigned REF_EDGES    = 16,
   parameter int unsigned EXP_CYCLES   = 64,
   parameter int unsigned TOL          = 2,
   parameter int unsigned LOCK_WINDOWS = 4,
   parameter int unsigned TIMEOUT      = 64,
   parameter int unsigned CW           = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ref_i,
   input  logic          en_i,
   output logic          lock_o,
   output logic [CW-1:0] count_o,
   output logic          count_valid_o,
   output logic          timeout_o
);

   // edge_cnt only needs to reach REF_EDGES-1 because the closing edge
   // restarts it; stall_cnt likewise tops out at TIMEOUT-1.
   localparam int unsigned EW = (REF_EDGES > 2) ? $clog2(REF_EDGES) : 1;
   localparam int unsigned SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GW = $clog2(LOCK_WINDOWS + 1);

   localparam logic [CW-1:0]        CNT_MAX    = '1;
   localparam logic [EW-1:0]        EDGE_LAST  = EW'(REF_EDGES - 1);
   localparam logic [SW-1:0]        STALL_LAST = SW'(TIMEOUT - 1);
   localparam logic [GW-1:0]        GOOD_FULL  = GW'(LOCK_WINDOWS);
   localparam logic signed [CW:0]   EXP_S      = (CW+1)'(EXP_CYCLES);
   localparam logic signed [CW:0]   TOL_S      = (CW+1)'(TOL);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   state_t              r_state;
   logic                r_sync1;
   logic                r_sync2;
   logic                r_sync3;
   logic [CW-1:0]       r_cyc_cnt;
   logic [EW-1:0]       r_edge_cnt;
   logic [GW-1:0]       r_good_cnt;
   logic [SW-1:0]       r_stall_cnt;
   logic                r_lock;
   logic [CW-1:0]       r_count;
   logic                r_count_valid;
   logic                r_timeout;

   logic                w_rise;
   logic [CW-1:0]       w_cyc_next;
   logic signed [CW:0]  w_diff;
   logic                w_good;
   logic [GW-1:0]       w_good_next;

   // r_sync1/r_sync2 resynchronise ref_i; r_sync3 is history for edge detect.
   assign w_rise = r_sync2 & ~r_sync3;

   // Saturating cycle count; on a closing edge this is also the window length.
   assign w_cyc_next = (r_cyc_cnt == CNT_MAX) ? CNT_MAX : r_cyc_cnt + CW'(1);

   // Signed deviation from the expected count, one bit wider than the counter.
   assign w_diff = $signed({1'b0, w_cyc_next}) - EXP_S;
   assign w_good = (w_diff <= TOL_S) && (w_diff >= -TOL_S);

   assign w_good_next = (r_good_cnt == GOOD_FULL) ? GOOD_FULL
                                                  : r_good_cnt + GW'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= IDLE;
         r_sync1       <= 1'b0;
         r_sync2       <= 1'b0;
         r_sync3       <= 1'b0;
         r_cyc_cnt     <= '0;
         r_edge_cnt    <= '0;
         r_good_cnt    <= '0;
         r_stall_cnt   <= '0;
         r_lock        <= 1'b0;
         r_count       <= '0;
         r_count_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_sync1       <= ref_i;
         r_sync2       <= r_sync1;
         r_sync3       <= r_sync2;
         r_count_valid <= 1'b0;

         if (!en_i || r_state == IDLE) begin
            // Disabled or idle: hold every counter and flag clear. count_o
            // keeps the last completed result.
            r_cyc_cnt   <= '0;
            r_edge_cnt  <= '0;
            r_good_cnt  <= '0;
            r_stall_cnt <= '0;
            r_lock      <= 1'b0;
            r_timeout   <= 1'b0;
            r_state     <= en_i ? ARM : IDLE;
         end else if (w_rise) begin
            // A reference edge always beats a stall expiring in the same
            // cycle, and it clears any standing timeout.
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
            if (r_state == ARM) begin
               r_state    <= MEASURE;
               r_cyc_cnt  <= '0;
               r_edge_cnt <= '0;
            end else if (r_edge_cnt == EDGE_LAST) begin
               // Closing edge of this window is the opening edge of the next.
               r_count       <= w_cyc_next;
               r_count_valid <= 1'b1;
               r_cyc_cnt     <= '0;
               r_edge_cnt    <= '0;
               if (w_good) begin
                  r_good_cnt <= w_good_next;
                  r_lock     <= (w_good_next == GOOD_FULL);
               end else begin
                  r_good_cnt <= '0;
                  r_lock     <= 1'b0;
               end
            end else begin
               r_cyc_cnt  <= w_cyc_next;
               r_edge_cnt <= r_edge_cnt + EW'(1);
            end
         end else if (r_stall_cnt == STALL_LAST) begin
            // Reference stalled: drop lock, discard the partial window and
            // wait in ARM for the next edge.
            r_timeout   <= 1'b1;
            r_lock      <= 1'b0;
            r_good_cnt  <= '0;
            r_stall_cnt <= '0;
            r_cyc_cnt   <= '0;
            r_edge_cnt  <= '0;
            r_state     <= ARM;
         end else begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
            if (r_state == MEASURE) begin
               r_cyc_cnt <= w_cyc_next;
            end
         end
      end
   end

   assign lock_o        = r_lock;
   assign count_o       = r_count;
   assign count_valid_o = r_count_valid;
   assign timeout_o     = r_timeout;

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameter REF_EDGES, default 16: reference rising edges per measurement window (>=2).
REQ-002 Parameter EXP_CYCLES, default 64: expected clk_i cycles per window (48 MHz clk_i, 12 MHz reference).
REQ-003 Parameter TOL, default 2: allowed absolute deviation from EXP_CYCLES (TOL < EXP_CYCLES).
REQ-004 Parameter LOCK_WINDOWS, default 4: consecutive good windows required to assert lock (>=1).
REQ-005 Parameter TIMEOUT, default 64: clk_i cycles without a detected reference edge before stall is declared (>=2).
REQ-006 Parameter CW, default 16: width of cycle counter and count_o.
REQ-007 clk_i  input  1  single clock, PLL output domain; all logic on its rising edge.
REQ-008 rst_i  input  1  synchronous, active-high reset.
REQ-009 ref_i  input  1  reference clock, asynchronous to clk_i, sampled as data.
REQ-010 en_i  input  1  monitor enable; low forces IDLE.
REQ-011 lock_o  output  1  frequency lock indication.
REQ-012 count_o  output  CW  clk_i cycle count of the last completed window.
REQ-013 count_valid_o  output  1  one-cycle pulse when count_o updates.
REQ-014 timeout_o  output  1  reference stall indication (level).

Function
REQ-015 ref_i SHALL pass through a 2-FF synchronizer plus one history FF; rise = sync2 & ~sync3; rise asserts 3 clk_i edges after ref_i goes high is sampled.
REQ-016 FSM SHALL have states IDLE, ARM, MEASURE; en_i low in any state -> IDLE next cycle.
REQ-017 IDLE: cycle, edge, good and stall counters SHALL be held at 0; lock_o=0, timeout_o=0, count_valid_o=0; en_i high -> ARM.
REQ-018 ARM: on rise -> MEASURE, cyc_cnt<=0, edge_cnt<=0; no count_valid_o.
REQ-019 MEASURE: each cycle cyc_cnt SHALL increment, saturating at 2^CW-1; each rise SHALL increment edge_cnt.
REQ-020 On the rise that brings edge_cnt to REF_EDGES, count_o<=cyc_cnt+1 (saturating), count_valid_o=1 next cycle, and a new window SHALL start on that same edge (cyc_cnt<=0, edge_cnt<=0), giving back-to-back windows with no gap.
REQ-021 Window good iff |count - EXP_CYCLES| <= TOL, computed with CW+1-bit signed arithmetic; bounds inclusive.
REQ-022 Good window: good_cnt increments, saturating at LOCK_WINDOWS; lock_o SHALL rise in the same cycle as the count_valid_o of the LOCK_WINDOWS-th consecutive good window.
REQ-023 Bad window: good_cnt<=0 and lock_o<=0, coinciding with that window's count_valid_o.
REQ-024 stall_cnt SHALL clear on every rise and otherwise increment in ARM/MEASURE; when stall_cnt==TIMEOUT-1 and no rise occurs: timeout_o<=1, lock_o<=0, good_cnt<=0, partial window discarded, state -> ARM.
REQ-025 Rise and timeout in the same cycle: rise SHALL win; no timeout.
REQ-026 timeout_o SHALL clear on the next rise; that rise is handled as the ARM window-start edge.
REQ-027 count_o SHALL hold its last value through IDLE, ARM and timeout; only rst_i clears it.

Reset
REQ-028 rst_i high at a clk_i edge SHALL set state=IDLE, all counters 0, lock_o=0, count_o=0, count_valid_o=0, timeout_o=0, synchronizer FFs 0, regardless of state or a window in progress.

Verification
REQ-029 Reset, en_i=1, ref_i period 4 clk_i (2H/2L) -> count_valid_o every 64 cycles with count_o=64; lock_o rises with the 4th pulse.
REQ-030 Tolerance edges: window of 14x4 + 2x5 periods -> count_o=66, good; window of 13x4 + 3x5 periods -> count_o=67, lock_o drops at that pulse. Repeat at 62 (good) and 61 (bad).
REQ-031 Locked, ref_i held low -> timeout_o=1 and lock_o=0 exactly 64 cycles after the last rise; restart ref_i -> timeout_o clears on the first rise; lock_o returns after 4 further good windows.
REQ-032 Rise on the cycle stall_cnt reaches 63 -> no timeout_o, window continues.
REQ-033 en_i low mid-window -> lock_o=0 next cycle, no count_valid_o, count_o unchanged; en_i high -> ARM, next count_o=64 after a full window.
REQ-034 rst_i pulsed mid-window while locked -> all outputs 0 the next cycle; ref_i stopped for 2^CW cycles with TIMEOUT raised to 2^CW+8 -> count_o saturates at 2^CW-1, window bad.
